fir_mac: RTL and testbench

//  Multiply-accumulate stage of the FIR engine, directly downstream of the tap-loop counter.
//  - Per sample: consumes the tap index stream (0..N-1) and its end-of-loop pulse from the counter.
//  - For each tap: reads sample x[k] from an internal delay line and coefficient c[k] from an

---
 rtl/fir_pkg.sv | 40 ++++
 rtl/fir_delay_line.sv | 30 +++
 rtl/fir_mac.sv | 118 +++++++++++
 tb/tb_fir_mac.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fir_pkg.sv
// Shared widths, FSM state type and output saturation for the FIR MAC stage.
// FIR_MAC_ROUND_EN selects round-half-up before the output shift; default is truncation.
package fir_pkg;

  localparam int DATA_W   = 16;
  localparam int COEF_W   = 16;
  localparam int TAPS_MAX = 32;
  localparam int ADDR_W   = $clog2(TAPS_MAX);
  localparam int PROD_W   = DATA_W + COEF_W;
  localparam int ACC_W    = PROD_W + ADDR_W;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    OUT   = 2'd3
  } fir_mac_state_t;

  localparam logic signed [ACC_W-1:0] Y_MAX = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] Y_MIN = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

  // Returns {ovf, y}: acc scaled back from Q1.(COEF_W-1) and clipped to DATA_W.
  function automatic logic [DATA_W:0] sat_dw(input logic signed [ACC_W-1:0] acc);
    logic signed [ACC_W-1:0] rnd;
    logic signed [ACC_W-1:0] sh;
`ifdef FIR_MAC_ROUND_EN
    rnd = acc + $signed(ACC_W'(2 ** (COEF_W - 2)));
`else
    rnd = acc;
`endif
    sh = rnd >>> (COEF_W - 1);
    if (sh > Y_MAX)
      return {1'b1, 1'b0, {(DATA_W-1){1'b1}}};
    else if (sh < Y_MIN)
      return {1'b1, 1'b1, {(DATA_W-1){1'b0}}};
    else
      return {1'b0, sh[DATA_W-1:0]};
  endfunction

endpackage

// File: rtl/fir_delay_line.sv
// Sample delay line (x[0] newest) with a registered read port feeding MAC stage S1.
module fir_delay_line
  import fir_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              shift,
  input  logic [DATA_W-1:0] sample,
  input  logic              rd,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] x [TAPS_MAX];

  // Read and shift share an edge, so a read in a shift cycle sees the pre-shift x[k].
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < TAPS_MAX; i++) x[i] <= '0;
      rd_data <= '0;
    end else begin
      if (shift) begin
        x[0] <= sample;
        for (int i = 1; i < TAPS_MAX; i++) x[i] <= x[i-1];
      end
      if (rd) rd_data <= x[rd_addr];
    end
  end

endmodule

// File: rtl/fir_mac.sv
// FIR multiply-accumulate: 3-stage MAC per tap, y_valid 3 cycles after tap_last.
// FIR_MAC_ROUND_EN (in fir_pkg) switches output scaling from truncation to round-half-up.
module fir_mac
  import fir_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              coef_we,
  input  logic [ADDR_W-1:0] coef_addr,
  input  logic [COEF_W-1:0] coef_data,
  input  logic              sample_valid,
  input  logic [DATA_W-1:0] sample_in,
  input  logic              tap_valid,
  input  logic [ADDR_W-1:0] tap_adres,
  input  logic              tap_last,
  output logic              busy,
  output logic              y_valid,
  output logic [DATA_W-1:0] y_out,
  output logic              y_ovf,
  output logic              sample_drop
);

  fir_mac_state_t state;
  logic           drain_cnt;

  logic [COEF_W-1:0] coef [TAPS_MAX];

  logic                     tap_take;
  logic                     s1_vld;
  logic [DATA_W-1:0]        s1_x;
  logic [COEF_W-1:0]        s1_c;
  logic                     s2_vld;
  logic signed [PROD_W-1:0] prod;
  logic signed [ACC_W-1:0]  acc;
  logic [DATA_W:0]          sat;

  assign tap_take    = tap_valid && !tap_last && (state == IDLE || state == RUN);
  assign busy        = (state != IDLE);
  assign sample_drop = sample_valid && busy;
  assign sat         = sat_dw(acc);

  fir_delay_line u_delay (
    .clk     (clk),
    .rst     (rst),
    .shift   (sample_valid && state == IDLE),
    .sample  (sample_in),
    .rd      (tap_take),
    .rd_addr (tap_adres),
    .rd_data (s1_x)
  );

  // A same-index write and read return the old coefficient (both sampled on one edge).
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < TAPS_MAX; i++) coef[i] <= '0;
      s1_c <= '0;
    end else begin
      if (coef_we) coef[coef_addr] <= coef_data;
      if (tap_take) s1_c <= coef[tap_adres];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_vld <= 1'b0;
      s2_vld <= 1'b0;
      prod   <= '0;
      acc    <= '0;
    end else begin
      s1_vld <= tap_take;
      s2_vld <= s1_vld;
      if (s1_vld) prod <= $signed(s1_x) * $signed(s1_c);
      if (state == IDLE && tap_take)
        acc <= '0;
      else if (s2_vld)
        acc <= acc + {{ADDR_W{prod[PROD_W-1]}}, prod};
    end
  end

  // Two DRAIN cycles let the last tap clear S2 and S3 before acc is sampled for y.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      drain_cnt <= 1'b0;
      y_valid   <= 1'b0;
      y_out     <= '0;
      y_ovf     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (tap_take) state <= RUN;
        end
        RUN: begin
          if (tap_last) begin
            state     <= DRAIN;
            drain_cnt <= 1'b0;
          end
        end
        DRAIN: begin
          if (drain_cnt) begin
            state   <= OUT;
            y_valid <= 1'b1;
            y_ovf   <= sat[DATA_W];
            y_out   <= sat[DATA_W-1:0];
          end else begin
            drain_cnt <= 1'b1;
          end
        end
        OUT: begin
          y_valid <= 1'b0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fir_mac.sv
// Directed self-checking bench for fir_mac with hand-computed expected outputs.
module tb_fir_mac;

  logic        clk = 1'b0;
  logic        rst;
  logic        coef_we;
  logic [4:0]  coef_addr;
  logic [15:0] coef_data;
  logic        sample_valid;
  logic [15:0] sample_in;
  logic        tap_valid;
  logic [4:0]  tap_adres;
  logic        tap_last;
  logic        busy;
  logic        y_valid;
  logic [15:0] y_out;
  logic        y_ovf;
  logic        sample_drop;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  fir_mac dut (
    .clk          (clk),
    .rst          (rst),
    .coef_we      (coef_we),
    .coef_addr    (coef_addr),
    .coef_data    (coef_data),
    .sample_valid (sample_valid),
    .sample_in    (sample_in),
    .tap_valid    (tap_valid),
    .tap_adres    (tap_adres),
    .tap_last     (tap_last),
    .busy         (busy),
    .y_valid      (y_valid),
    .y_out        (y_out),
    .y_ovf        (y_ovf),
    .sample_drop  (sample_drop)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [15:0] v);
    sample_valid = 1'b1;
    sample_in    = v;
    tick();
    sample_valid = 1'b0;
  endtask

  task automatic wcoef(input int a, input logic [15:0] d);
    coef_we   = 1'b1;
    coef_addr = 5'(a);
    coef_data = d;
    tick();
    coef_we = 1'b0;
  endtask

  // Drives one loop (-1 entries are bubbles), optionally a sample_valid at index drop_at.
  task automatic do_loop(input int taps[$], input int drop_at, output int lat,
                         output logic [15:0] y, output logic ovf,
                         output bit busy_ok, output bit drop_seen);
    busy_ok = 1'b1; drop_seen = 1'b0; lat = -1; y = '0; ovf = 1'b0;
    foreach (taps[i]) begin
      tap_valid    = (taps[i] >= 0);
      tap_adres    = 5'(taps[i]);
      sample_valid = (i == drop_at);
      sample_in    = 16'h1234;
      #1;
      if (sample_valid && sample_drop) drop_seen = 1'b1;
      tick();
      if (!busy) busy_ok = 1'b0;
    end
    tap_valid = 1'b0; sample_valid = 1'b0; tap_last = 1'b1;
    tick();
    tap_last = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      if (!busy) busy_ok = 1'b0;
      if (y_valid) begin
        lat = c; y = y_out; ovf = y_ovf;
        break;
      end
      tick();
    end
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    checks++; if (y_valid !== 1'b0) begin failures++; $display("FAIL reset_y_valid: got %b expected 0", y_valid); end
    rst = 1'b0;
    tick();
    checks++; if (y_out !== 16'h0000) begin failures++; $display("FAIL reset_y_out: got %h expected 0000", y_out); end
    checks++; if (y_ovf !== 1'b0) begin failures++; $display("FAIL reset_y_ovf: got %b expected 0", y_ovf); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (sample_drop !== 1'b0) begin failures++; $display("FAIL reset_sample_drop: got %b expected 0", sample_drop); end
  endtask

  task automatic test_identity();
    int q[$]; int lat; logic [15:0] y; logic ovf; bit bok; bit ds;
    logic [15:0] exp_y;
`ifdef FIR_MAC_ROUND_EN
    exp_y = 16'd1000;
`else
    exp_y = 16'd999;
`endif
    wcoef(0, 16'h7FFF);
    push(16'd1000);
    q = {0, 1, 2, 3};
    do_loop(q, -1, lat, y, ovf, bok, ds);
    checks++; if (lat !== 3) begin failures++; $display("FAIL identity_latency: got %0d expected 3", lat); end
    checks++; if (y !== exp_y) begin failures++; $display("FAIL identity_y: got %0d expected %0d", $signed(y), $signed(exp_y)); end
    checks++; if (ovf !== 1'b0) begin failures++; $display("FAIL identity_ovf: got %b expected 0", ovf); end
  endtask

  task automatic test_four_tap();
    int q[$]; int lat; logic [15:0] y; logic ovf; bit bok; bit ds;
    for (int i = 0; i < 4; i++) wcoef(i, 16'h4000);
    push(16'd100); push(16'd200); push(16'd300); push(16'd400);
    q = {0, 1, 2, 3};
    do_loop(q, -1, lat, y, ovf, bok, ds);
    checks++; if (y !== 16'd500) begin failures++; $display("FAIL four_tap_y: got %0d expected 500", $signed(y)); end
    checks++; if (bok !== 1'b1) begin failures++; $display("FAIL four_tap_busy: got %b expected 1", bok); end
  endtask

  task automatic test_bubbles();
    int q[$]; int lat; logic [15:0] y; logic ovf; bit bok; bit ds;
    q = {0, -1, 1, -1, -1, 2};
    do_loop(q, -1, lat, y, ovf, bok, ds);
    checks++; if (y !== 16'd450) begin failures++; $display("FAIL bubbles_y: got %0d expected 450", $signed(y)); end
    checks++; if (bok !== 1'b1) begin failures++; $display("FAIL bubbles_busy: got %b expected 1", bok); end
    checks++; if (lat !== 3) begin failures++; $display("FAIL bubbles_latency: got %0d expected 3", lat); end
    q = {0, 1, 2};
    do_loop(q, -1, lat, y, ovf, bok, ds);
    checks++; if (y !== 16'd450) begin failures++; $display("FAIL contiguous_y: got %0d expected 450", $signed(y)); end
  endtask

  task automatic test_drop_zero_loop();
    int q[$]; int lat; logic [15:0] y; logic ovf; bit bok; bit ds;
    bit seen_y; bit seen_busy;
    q = {0, 1, 2, 3};
    do_loop(q, 2, lat, y, ovf, bok, ds);
    checks++; if (ds !== 1'b1) begin failures++; $display("FAIL drop_pulse: got %b expected 1", ds); end
    checks++; if (y !== 16'd500) begin failures++; $display("FAIL drop_loop_y: got %0d expected 500", $signed(y)); end
    do_loop(q, -1, lat, y, ovf, bok, ds);
    checks++; if (y !== 16'd500) begin failures++; $display("FAIL drop_line_unchanged: got %0d expected 500", $signed(y)); end
    tap_last = 1'b1;
    tick();
    tap_last = 1'b0;
    seen_y = 1'b0; seen_busy = 1'b0;
    for (int c = 0; c < 8; c++) begin
      if (y_valid) seen_y = 1'b1;
      if (busy) seen_busy = 1'b1;
      tick();
    end
    checks++; if (seen_y !== 1'b0) begin failures++; $display("FAIL zero_loop_y_valid: got %b expected 0", seen_y); end
    checks++; if (seen_busy !== 1'b0) begin failures++; $display("FAIL zero_loop_busy: got %b expected 0", seen_busy); end
  endtask

  // First tap coincides with a shift and a write to the same coefficient.
  task automatic test_same_cycle();
    int q[$]; int lat; logic [15:0] y; logic ovf; bit bok; bit ds;
    bit got;
    tap_valid = 1'b1; tap_adres = 5'd0;
    sample_valid = 1'b1; sample_in = 16'd500;
    coef_we = 1'b1; coef_addr = 5'd0; coef_data = 16'h0000;
    tick();
    tap_valid = 1'b0; sample_valid = 1'b0; coef_we = 1'b0; tap_last = 1'b1;
    tick();
    tap_last = 1'b0;
    got = 1'b0; y = '0;
    for (int c = 1; c <= 10; c++) begin
      if (y_valid) begin got = 1'b1; y = y_out; break; end
      tick();
    end
    tick();
    checks++; if (got !== 1'b1 || y !== 16'd200) begin failures++; $display("FAIL same_cycle_old_values: got valid=%b y=%0d expected valid=1 y=200", got, $signed(y)); end
    q = {0, 1};
    do_loop(q, -1, lat, y, ovf, bok, ds);
    checks++; if (y !== 16'd200) begin failures++; $display("FAIL same_cycle_after: got %0d expected 200", $signed(y)); end
  endtask

  task automatic test_saturation();
    int q[$]; int lat; logic [15:0] y; logic ovf; bit bok; bit ds;
    for (int i = 0; i < 32; i++) wcoef(i, 16'h7FFF);
    for (int i = 0; i < 32; i++) push(16'h7FFF);
    q = {};
    for (int i = 0; i < 32; i++) q.push_back(i);
    do_loop(q, -1, lat, y, ovf, bok, ds);
    checks++; if (y !== 16'h7FFF) begin failures++; $display("FAIL sat_pos_y: got %h expected 7fff", y); end
    checks++; if (ovf !== 1'b1) begin failures++; $display("FAIL sat_pos_ovf: got %b expected 1", ovf); end
    for (int i = 0; i < 32; i++) push(16'h8000);
    do_loop(q, -1, lat, y, ovf, bok, ds);
    checks++; if (y !== 16'h8000) begin failures++; $display("FAIL sat_neg_y: got %h expected 8000", y); end
    checks++; if (ovf !== 1'b1) begin failures++; $display("FAIL sat_neg_ovf: got %b expected 1", ovf); end
  endtask

  task automatic test_reset_mid_run();
    int q[$]; int lat; logic [15:0] y; logic ovf; bit bok; bit ds;
    bit bad;
    tap_valid = 1'b1; tap_adres = 5'd0;
    tick();
    tap_adres = 5'd1;
    tick();
    tap_valid = 1'b0; rst = 1'b1;
    tick();
    rst = 1'b0;
    bad = 1'b0;
    for (int c = 0; c < 6; c++) begin
      if (y_valid !== 1'b0 || y_out !== 16'h0000 || busy !== 1'b0) bad = 1'b1;
      tick();
    end
    checks++; if (bad !== 1'b0) begin failures++; $display("FAIL mid_reset_outputs: got nonzero=%b expected 0", bad); end
    push(16'd5); push(16'd6); push(16'd7); push(16'd8);
    q = {0, 1, 2, 3};
    do_loop(q, -1, lat, y, ovf, bok, ds);
    checks++; if (lat !== 3) begin failures++; $display("FAIL post_reset_latency: got %0d expected 3", lat); end
    checks++; if (y !== 16'h0000) begin failures++; $display("FAIL post_reset_y: got %0d expected 0", $signed(y)); end
  endtask

  initial begin
    rst = 1'b1; coef_we = 1'b0; coef_addr = '0; coef_data = '0;
    sample_valid = 1'b0; sample_in = '0;
    tap_valid = 1'b0; tap_adres = '0; tap_last = 1'b0;
    test_reset();
    test_identity();
    test_four_tap();
    test_bubbles();
    test_drop_zero_loop();
    test_same_cycle();
    test_saturation();
    test_reset_mid_run();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
